prbs_checker: RTL
=================

# prbs_checker

Receive-side companion to the PRBS generator: samples a serial PRBS stream at the same user-programmed rate, self-synchronises a local copy of the 8-stage XNOR LFSR (taps 8,6,5,4), declares lock, and counts bit errors. Sits at the far end of the PRBS link for loopback and bit-error-rate measurement.

## Interface
- LFSR_WIDTH, 8, LFSR length
- TAP1, 6, feedback tap (1-based stage)
- TAP2, 5, feedback tap
- TAP3, 4, feedback tap
- LOCK_COUNT, 16, consecutive matches in VERIFY required to lock
- UNLOCK_ERRS, 4, errors within one 256-sample window that drop lock
- clk  in  1  single clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- user_freq  in  32  sample divider, same meaning as the generator's
- signal_in  in  1  received PRBS bit
- clear_counts  in  1  synchronous clear of error_count and sym_count
- inject_err  in  1  self-test bit flip (active only with the macro in Configuration)
- locked  out  1  checker is in LOCKED
- bit_error  out  1  one-clk pulse per mismatched sample while LOCKED
- error_count  out  32  saturating count of bit errors
- sym_count  out  32  saturating count of samples taken while LOCKED

## Operation
- Divider: `div_cnt` runs 0..user_freq-1. On `div_cnt == user_freq-1` it returns to 0 and registered `bit_en` is 1 for the next clk; otherwise `bit_en` is 0. user_freq=0 gives a 2^32-cycle period (32-bit wrap). This matches the generator exactly.
- All actions below occur only on clks with `bit_en=1`. Sampled bit b = signal_in (XOR inject_err when the macro is enabled).
- Local register R[7:0] shifts left with the new bit entering at R[0]. Prediction p = ~(R[7]^R[TAP1-1]^R[TAP2-1]^R[TAP3-1]).
- SEARCH: shift b into R and increment `fill`. When `fill` reaches LFSR_WIDTH, go to VERIFY with `match_cnt`=0.
- VERIFY: compare b with p and shift b into R.
  - Match increments `match_cnt`. At LOCK_COUNT go to LOCKED and clear `win_cnt` and `win_errs`.
  - Mismatch goes to SEARCH with `fill`=0.
  - R==8'hFF (the XNOR lock-up state; a constant-1 input satisfies the recurrence) forces SEARCH with `fill`=0 and never locks.
- LOCKED: shift p (not b) into R, so errors do not propagate.
  - `sym_count` increments.
  - On mismatch: pulse `bit_error`, increment `error_count` and `win_errs`.
  - `win_cnt` (8-bit) increments every sample. On wrap FF->00, `win_errs` clears; an error on that same sample leaves it at 1.
  - When `win_errs` reaches UNLOCK_ERRS, go to SEARCH with `fill`=0. The error that causes this is still counted.
- Counters saturate at 32'hFFFF_FFFF. `clear_counts` zeroes both counters; a clear coinciding with an increment leaves them at 0.

## Timing
- Reset (reset_n=0 at a clk edge) sets:
  - locked=0, bit_error=0, error_count=0, sym_count=0
  - state SEARCH, R=0, fill=0, div_cnt=0, bit_en=0
- Reset mid-operation aborts lock at that edge.
- First `bit_en` occurs user_freq+1 clks after reset release.
- Minimum lock: LFSR_WIDTH+LOCK_COUNT = 24 error-free samples. `locked` rises at the edge that samples the 24th bit.
- `bit_error` and the `error_count` increment appear at the edge that samples the erroneous bit. On the UNLOCK_ERRS-th error, `locked` falls at that same edge.
- A stream whose bits change at the generator's enable edges is sampled one symbol late. This offset is harmless because the checker is self-synchronising.

## Configuration
- PRBS_CHK_ERR_INJECT_EN defined: a sampled bit is inverted when inject_err=1 on a `bit_en` clk.
- Not defined: inject_err is ignored and no XOR is present in the datapath.

## Test plan
- Valid PRBS stream, user_freq=1, no errors -> locked=1 after 24 samples; error_count=0 and sym_count=1000 after 1000 further samples.
- While locked, flip one bit -> one bit_error pulse, error_count=1, locked stays 1.
- While locked, flip 4 bits within 256 samples -> locked falls on the 4th flip, error_count=4, relock after 24 good samples.
- user_freq=4 -> sampling every 4 clks; locked rises 4*24+1 clks after reset release.
- signal_in constant 1 or constant 0 for 500 samples -> locked never asserts, error_count=0.
- clear_counts on the same clk as an error -> error_count=0. reset_n=0 while locked -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/prbs_checker.sv
// prbs_checker: receive-side PRBS checker for the 8-stage XNOR LFSR link.
// Samples signal_in at the programmed rate, self-synchronises a local LFSR
// copy, declares lock and counts bit errors over saturating counters.
// Optional build macro: PRBS_CHK_ERR_INJECT_EN adds an inject_err bit flip
// on the sampled bit; without it inject_err is ignored.
module prbs_checker #(
  parameter int LFSR_WIDTH  = 8,
  parameter int TAP1        = 6,
  parameter int TAP2        = 5,
  parameter int TAP3        = 4,
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] user_freq,
  input  logic        signal_in,
  input  logic        clear_counts,
  input  logic        inject_err,
  output logic        locked,
  output logic        bit_error,
  output logic [31:0] error_count,
  output logic [31:0] sym_count
);

  localparam int FILL_W  = $clog2(LFSR_WIDTH + 1);
  localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);
  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(LFSR_WIDTH - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_COUNT - 1);
  localparam logic [WERR_W-1:0]  WERR_LIMIT = WERR_W'(UNLOCK_ERRS);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t                  state_reg, state_next;
  logic [31:0]             div_cnt_reg;
  logic                    bit_en_reg;
  logic [LFSR_WIDTH-1:0]   r_reg, r_next;
  logic [FILL_W-1:0]       fill_reg, fill_next;
  logic [MATCH_W-1:0]      match_reg, match_next;
  logic [7:0]              win_cnt_reg, win_cnt_next;
  logic [WERR_W-1:0]       win_errs_reg, win_errs_next, werr_base;
  logic                    bit_error_reg;
  logic [31:0]             error_count_reg, sym_count_reg;
  logic                    sample_bit, pred_bit, err_hit, sym_hit;

`ifdef PRBS_CHK_ERR_INJECT_EN
  assign sample_bit = signal_in ^ inject_err;
`else
  logic unused_inject;
  assign unused_inject = inject_err;
  assign sample_bit    = signal_in;
`endif

  // XNOR of the tapped stages predicts the next stream bit
  assign pred_bit = ~(r_reg[LFSR_WIDTH-1] ^ r_reg[TAP1-1] ^ r_reg[TAP2-1] ^ r_reg[TAP3-1]);

  // Rate divider: one-clk bit_en pulse after each user_freq-long period
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt_reg <= '0;
      bit_en_reg  <= 1'b0;
    end else if (div_cnt_reg == user_freq - 32'd1) begin
      div_cnt_reg <= '0;
      bit_en_reg  <= 1'b1;
    end else begin
      div_cnt_reg <= div_cnt_reg + 32'd1;
      bit_en_reg  <= 1'b0;
    end
  end

  // Next-state and datapath decisions for the search/verify/locked machine
  always_comb begin
    state_next    = state_reg;
    r_next        = r_reg;
    fill_next     = fill_reg;
    match_next    = match_reg;
    win_cnt_next  = win_cnt_reg;
    win_errs_next = win_errs_reg;
    werr_base     = win_errs_reg;
    err_hit       = 1'b0;
    sym_hit       = 1'b0;
    if (bit_en_reg) begin
      case (state_reg)
        SEARCH: begin
          r_next    = {r_reg[LFSR_WIDTH-2:0], sample_bit};
          fill_next = fill_reg + FILL_W'(1);
          if (fill_reg == FILL_LAST) begin
            state_next = VERIFY;
            match_next = '0;
          end
        end
        VERIFY: begin
          r_next = {r_reg[LFSR_WIDTH-2:0], sample_bit};
          // All-ones is the XNOR lock-up state and must never be trusted
          if ((r_reg == '1) || (sample_bit != pred_bit)) begin
            state_next = SEARCH;
            fill_next  = '0;
          end else if (match_reg == MATCH_LAST) begin
            state_next    = LOCKED;
            win_cnt_next  = '0;
            win_errs_next = '0;
          end else begin
            match_next = match_reg + MATCH_W'(1);
          end
        end
        LOCKED: begin
          // Feed back the prediction so a received error does not propagate
          r_next        = {r_reg[LFSR_WIDTH-2:0], pred_bit};
          sym_hit       = 1'b1;
          err_hit       = sample_bit ^ pred_bit;
          win_cnt_next  = win_cnt_reg + 8'd1;
          werr_base     = (win_cnt_reg == 8'hFF) ? '0 : win_errs_reg;
          win_errs_next = werr_base + WERR_W'(err_hit);
          if (err_hit && (win_errs_next == WERR_LIMIT)) begin
            state_next = SEARCH;
            fill_next  = '0;
          end
        end
        default: begin
          state_next = SEARCH;
          fill_next  = '0;
        end
      endcase
    end
  end

  // State and local LFSR registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= SEARCH;
      r_reg         <= '0;
      fill_reg      <= '0;
      match_reg     <= '0;
      win_cnt_reg   <= '0;
      win_errs_reg  <= '0;
      bit_error_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      r_reg         <= r_next;
      fill_reg      <= fill_next;
      match_reg     <= match_next;
      win_cnt_reg   <= win_cnt_next;
      win_errs_reg  <= win_errs_next;
      bit_error_reg <= err_hit;
    end
  end

  // Saturating error/sample counters; a clear wins over a same-clk increment
  always_ff @(posedge clk) begin
    if (!reset_n || clear_counts) begin
      error_count_reg <= '0;
      sym_count_reg   <= '0;
    end else begin
      if (err_hit && (error_count_reg != '1)) error_count_reg <= error_count_reg + 32'd1;
      if (sym_hit && (sym_count_reg != '1))   sym_count_reg   <= sym_count_reg + 32'd1;
    end
  end

  assign locked      = (state_reg == LOCKED);
  assign bit_error   = bit_error_reg;
  assign error_count = error_count_reg;
  assign sym_count   = sym_count_reg;

endmodule
